// File: rtl/rep_seq_checker.sv
// On-chip monitor for "rose(b) |-> a[=MIN_REP:MAX_REP] ##1 b": one registered
// pass/fail verdict per triggered attempt, plus error cause, live count and tallies.
module rep_seq_checker #(
    parameter int MIN_REP = 2,
    parameter int MAX_REP = 3,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 4,
    parameter int TALLY_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               a,
    input  logic               b,
    output logic               busy,
    output logic               pass,
    output logic               fail,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   rep_cnt,
    output logic [TALLY_W-1:0] pass_tally,
    output logic [TALLY_W-1:0] fail_tally
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OVER    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    // The wait counter only ever has to reach TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0]   REP_MIN   = CNT_W'(MIN_REP);
    localparam logic [CNT_W-1:0]   REP_MAX   = CNT_W'(MAX_REP);
    localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        if (v == TALLY_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(TALLY_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t             state_q, state_d;
    logic               b_q;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [TALLY_W-1:0] pass_tally_q, pass_tally_d;
    logic [TALLY_W-1:0] fail_tally_q, fail_tally_d;

    logic rose_b_s;
    logic in_window_s;

    assign rose_b_s    = b & ~b_q;
    assign in_window_s = (rep_q >= REP_MIN) && (rep_q <= REP_MAX);

    // Next-state, verdict and counter logic.
    always_comb begin
        state_d    = state_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        err_d      = err_q;
        rep_d      = rep_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (en && rose_b_s) begin
                    // The trigger edge's own a counts (overlapping implication).
                    state_d    = ST_ARMED;
                    rep_d      = a ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
                    wait_cnt_d = {WAIT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!en) begin
                    fail_d  = 1'b1;
                    err_d   = ERR_ABORT;
                    state_d = ST_IDLE;
                end else if (b && in_window_s) begin
                    pass_d  = 1'b1;
                    err_d   = ERR_NONE;
                    state_d = ST_IDLE;
                end else if (a && (rep_q == REP_MAX)) begin
                    fail_d  = 1'b1;
                    err_d   = ERR_OVER;
                    state_d = ST_IDLE;
                end else begin
                    if (a) begin
                        rep_d = rep_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        rep_d = rep_q;
                    end
                    if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
                        fail_d  = 1'b1;
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARMED);

        if (pass_d) begin
            pass_tally_d = sat_inc(pass_tally_q);
        end else begin
            pass_tally_d = pass_tally_q;
        end
        if (fail_d) begin
            fail_tally_d = sat_inc(fail_tally_q);
        end else begin
            fail_tally_d = fail_tally_q;
        end
    end

    // State, outputs and counters register; b is delayed unconditionally for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_q        <= ERR_NONE;
            rep_q        <= {CNT_W{1'b0}};
            wait_cnt_q   <= {WAIT_W{1'b0}};
            pass_tally_q <= {TALLY_W{1'b0}};
            fail_tally_q <= {TALLY_W{1'b0}};
        end else begin
            state_q      <= state_d;
            b_q          <= b;
            busy_q       <= busy_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            err_q        <= err_d;
            rep_q        <= rep_d;
            wait_cnt_q   <= wait_cnt_d;
            pass_tally_q <= pass_tally_d;
            fail_tally_q <= fail_tally_d;
        end
    end

    assign busy       = busy_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign err_code   = err_q;
    assign rep_cnt    = rep_q;
    assign pass_tally = pass_tally_q;
    assign fail_tally = fail_tally_q;

endmodule

// File: tb/tb_rep_seq_checker.sv
// Directed bench for rep_seq_checker (default parameters), checked with immediate assertions.
module tb_rep_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       a;
    logic       b;
    logic       busy;
    logic       pass;
    logic       fail;
    logic [1:0] err_code;
    logic [3:0] rep_cnt;
    logic [7:0] pass_tally;
    logic [7:0] fail_tally;

    int checks = 0;
    int errors = 0;

    rep_seq_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .err_code   (err_code),
        .rep_cnt    (rep_cnt),
        .pass_tally (pass_tally),
        .fail_tally (fail_tally)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sampled edge: inputs set at negedge, outputs observed 1ns after posedge.
    task automatic step(input logic e, input logic av, input logic bv);
        @(negedge clk);
        en = e;
        a  = av;
        b  = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_rep", 32'(rep_cnt), 32'd0);
        check("rst_ptally", 32'(pass_tally), 32'd0);
        check("rst_ftally", 32'(fail_tally), 32'd0);
        rst_n = 1'b1;

        // en low blocks the trigger; a held-high b does not trigger later.
        step(1'b0, 1'b0, 1'b1);
        check("en_low_no_trig", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        check("level_b_no_trig", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 1'b0);

        // Basic pass: a at N+2, N+4, b at N+6.
        step(1'b1, 1'b0, 1'b1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rep0", 32'(rep_cnt), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t1_rep2", 32'(rep_cnt), 32'd2);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_nofail", 32'(fail), 32'd0);
        check("t1_busy0", 32'(busy), 32'd0);
        check("t1_rep", 32'(rep_cnt), 32'd2);
        check("t1_err", 32'(err_code), 32'd0);
        check("t1_ptally", 32'(pass_tally), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("t1_pass_1cyc", 32'(pass), 32'd0);

        // Over-repetition: a at N, N+3, N+5, N+7 with no b.
        step(1'b1, 1'b1, 1'b1);
        check("t2_rep1", 32'(rep_cnt), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t2_rep3", 32'(rep_cnt), 32'd3);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t2_fail", 32'(fail), 32'd1);
        check("t2_nopass", 32'(pass), 32'd0);
        check("t2_err", 32'(err_code), 32'd1);
        check("t2_rep", 32'(rep_cnt), 32'd3);
        check("t2_ftally", 32'(fail_tally), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("t2_fail_1cyc", 32'(fail), 32'd0);
        check("t2_rep_hold", 32'(rep_cnt), 32'd3);

        // Timeout: trigger at N, a at N+2, fail decided at edge N+32.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 3; k <= 31; k++) begin
            step(1'b1, 1'b0, 1'b0);
        end
        check("t3_busy_n31", 32'(busy), 32'd1);
        check("t3_nofail_n31", 32'(fail), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_err", 32'(err_code), 32'd2);
        check("t3_busy0", 32'(busy), 32'd0);
        check("t3_rep", 32'(rep_cnt), 32'd1);
        check("t3_ftally", 32'(fail_tally), 32'd2);

        // Early b ignored, re-trigger ignored, then pass.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("t4_early_b_nopass", 32'(pass), 32'd0);
        check("t4_early_b_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("t4_retrig_rep", 32'(rep_cnt), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("t4_pass", 32'(pass), 32'd1);
        check("t4_rep", 32'(rep_cnt), 32'd2);
        check("t4_err", 32'(err_code), 32'd0);
        check("t4_ptally", 32'(pass_tally), 32'd2);
        step(1'b1, 1'b0, 1'b1);
        check("t4_verdict_no_retrig", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 1'b0);

        // Abort: en dropped at N+3.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("t5_fail", 32'(fail), 32'd1);
        check("t5_err", 32'(err_code), 32'd3);
        check("t5_busy0", 32'(busy), 32'd0);
        check("t5_ftally", 32'(fail_tally), 32'd3);
        step(1'b0, 1'b0, 1'b1);
        check("t5_idle_en_low_busy", 32'(busy), 32'd0);
        check("t5_idle_err_hold", 32'(err_code), 32'd3);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("t5_rearm", 32'(busy), 32'd1);

        // Asynchronous reset mid-attempt, observed between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_arst_busy", 32'(busy), 32'd0);
        check("t5_arst_err", 32'(err_code), 32'd0);
        check("t5_arst_rep", 32'(rep_cnt), 32'd0);
        check("t5_arst_ptally", 32'(pass_tally), 32'd0);
        check("t5_arst_ftally", 32'(fail_tally), 32'd0);
        @(negedge clk);
        a     = 1'b0;
        b     = 1'b0;
        rst_n = 1'b1;

        // 300 passing attempts: pass_tally saturates at 255.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b1);
            if (i == 0) begin
                check("t6_first_pass", 32'(pass), 32'd1);
                check("t6_ptally_1", 32'(pass_tally), 32'd1);
            end
            if (i == 254) begin
                check("t6_ptally_255", 32'(pass_tally), 32'd255);
            end
            if (i == 255) begin
                check("t6_ptally_sat", 32'(pass_tally), 32'd255);
            end
            step(1'b1, 1'b0, 1'b0);
        end
        check("t6_ptally_final", 32'(pass_tally), 32'd255);
        check("t6_ftally_final", 32'(fail_tally), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
